// File: rtl/free_list_pkg.sv
// Shared sizing and tag/pointer types for the rename free list.
// Includes a small helper for counting rename slots.
package free_list_pkg;

  localparam int FL_PHY_REGS  = 64;
  localparam int FL_ARCH_REGS = 32;
  localparam int FL_PHY_WIDTH = 6;

  typedef logic [FL_PHY_WIDTH-1:0] phy_tag_t;
  typedef logic [FL_PHY_WIDTH:0]   fl_ptr_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/free_list.sv
// Rename-stage physical register free list: circular FIFO of free tags with
// a speculative head, a committed head for flush recovery, and a release tail.
module free_list
  import free_list_pkg::*;
#(
  parameter int PHY_REGS  = FL_PHY_REGS,
  parameter int ARCH_REGS = FL_ARCH_REGS,
  parameter int PHY_WIDTH = FL_PHY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_ready,
  output logic [PHY_WIDTH-1:0] alloc_phy_0,
  output logic [PHY_WIDTH-1:0] alloc_phy_1,
  output logic [1:0]           busy_valid,
  output logic [PHY_WIDTH-1:0] rd_phy_busy_0,
  output logic [PHY_WIDTH-1:0] rd_phy_busy_1,
  input  logic                 retire_valid,
  input  logic                 retire_has_rd,
  input  logic [PHY_WIDTH-1:0] rd_phy_old_commit,
  output logic [PHY_WIDTH:0]   free_count,
  output logic                 empty
);

  typedef logic [PHY_WIDTH-1:0] tag_t;
  typedef logic [PHY_WIDTH:0]   ptr_t;

  localparam ptr_t PTR_FULL   = ptr_t'(PHY_REGS);
  localparam ptr_t TAIL_RESET = ptr_t'(PHY_REGS - ARCH_REGS);

  tag_t mem_q [PHY_REGS];
  tag_t mem_d [PHY_REGS];
  ptr_t head_q, head_d;
  ptr_t commit_head_q, commit_head_d;
  ptr_t tail_q, tail_d;

  ptr_t req_cnt;
  tag_t rd_idx_0, rd_idx_1;
  logic grant;
  logic release_en;

  always_comb begin
    req_cnt    = {{(PHY_WIDTH-1){1'b0}}, popcount2(alloc_req)};
    free_count = tail_q - head_q;
    empty      = (free_count == '0);

    // Slot 1 skips past slot 0's tag only when slot 0 is also requesting.
    rd_idx_0    = head_q[PHY_WIDTH-1:0];
    rd_idx_1    = head_q[PHY_WIDTH-1:0] + {{(PHY_WIDTH-1){1'b0}}, alloc_req[0]};
    alloc_phy_0 = mem_q[rd_idx_0];
    alloc_phy_1 = mem_q[rd_idx_1];

    alloc_ready   = (free_count >= req_cnt);
    grant         = alloc_ready & ~flush;
    busy_valid    = alloc_req & {2{grant}};
    rd_phy_busy_0 = alloc_phy_0;
    rd_phy_busy_1 = alloc_phy_1;

    release_en = retire_valid & retire_has_rd & (rd_phy_old_commit != '0);
  end

  always_comb begin
    mem_d         = mem_q;
    tail_d        = tail_q;
    commit_head_d = commit_head_q;
    head_d        = head_q;

    if (release_en) begin
      mem_d[tail_q[PHY_WIDTH-1:0]] = rd_phy_old_commit;
      tail_d        = tail_q + {{PHY_WIDTH{1'b0}}, 1'b1};
      commit_head_d = commit_head_q + {{PHY_WIDTH{1'b0}}, 1'b1};
    end

    // Flush rewinds to the committed head, counting a retire in the same cycle.
    if (flush) begin
      head_d = commit_head_d;
    end else if (grant) begin
      head_d = head_q + req_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PHY_REGS; k++) begin
        mem_q[k] <= (k < PHY_REGS - ARCH_REGS) ? tag_t'(ARCH_REGS + k) : '0;
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= TAIL_RESET;
    end else begin
      mem_q         <= mem_d;
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

`ifndef SYNTHESIS
  logic [PHY_REGS-1:0] seen;
  logic                dup_tag;
  tag_t                win_idx;
  ptr_t                committed_cnt;

  always_comb begin
    seen          = '0;
    dup_tag       = 1'b0;
    win_idx       = '0;
    committed_cnt = tail_q - commit_head_q;
    for (int i = 0; i < PHY_REGS; i++) begin
      if (ptr_t'(i) < free_count) begin
        win_idx = head_q[PHY_WIDTH-1:0] + tag_t'(i);
        if (seen[mem_q[win_idx]]) dup_tag = 1'b1;
        seen[mem_q[win_idx]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_commit_window: assert (committed_cnt <= PTR_FULL)
        else $error("free_list: tail ran more than PHY_REGS past commit_head");
      a_head_le_tail: assert (free_count <= PTR_FULL)
        else $error("free_list: head passed tail");
      a_no_dup: assert (!dup_tag)
        else $error("free_list: duplicate tag in free window");
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed and randomized bench for free_list against a queue-based model of
// the free set (committed queue plus a count of speculatively taken tags).
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic [1:0] alloc_req;
  logic       alloc_ready;
  logic [5:0] alloc_phy_0, alloc_phy_1;
  logic [1:0] busy_valid;
  logic [5:0] rd_phy_busy_0, rd_phy_busy_1;
  logic       retire_valid, retire_has_rd;
  logic [5:0] rd_phy_old_commit;
  logic [6:0] free_count;
  logic       empty;

  always #5 clk = ~clk;

  free_list dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_req(alloc_req),
    .alloc_ready(alloc_ready), .alloc_phy_0(alloc_phy_0), .alloc_phy_1(alloc_phy_1),
    .busy_valid(busy_valid), .rd_phy_busy_0(rd_phy_busy_0), .rd_phy_busy_1(rd_phy_busy_1),
    .retire_valid(retire_valid), .retire_has_rd(retire_has_rd),
    .rd_phy_old_commit(rd_phy_old_commit), .free_count(free_count), .empty(empty)
  );

  int checks = 0;
  int errors = 0;

  // fq: tags from the committed head to the tail, in FIFO order.
  // nspec: how many of those have been handed out speculatively.
  int fq[$];
  int nspec;
  int inflight[$];
  bit track;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    fq.delete();
    for (int i = 0; i < 32; i++) fq.push_back(32 + i);
    nspec = 0;
    inflight.delete();
  endfunction

  task automatic step(input string tag);
    int  n, avail, r0;
    bit  rdy, rel;
    @(negedge clk);
    r0    = int'(alloc_req[0]);
    n     = r0 + int'(alloc_req[1]);
    avail = fq.size() - nspec;
    rdy   = (avail >= n);
    if (!rst) begin
      chk({tag, ".free_count"}, 32'(free_count), avail);
      chk({tag, ".empty"}, 32'(empty), 32'(avail == 0));
      chk({tag, ".alloc_ready"}, 32'(alloc_ready), 32'(rdy));
      chk({tag, ".busy_valid"}, 32'(busy_valid), (rdy && !flush) ? 32'(alloc_req) : 32'd0);
      if (avail >= 1) begin
        chk({tag, ".alloc_phy_0"}, 32'(alloc_phy_0), fq[nspec]);
        chk({tag, ".rd_phy_busy_0"}, 32'(rd_phy_busy_0), fq[nspec]);
      end
      if (avail >= 1 + r0) begin
        chk({tag, ".alloc_phy_1"}, 32'(alloc_phy_1), fq[nspec + r0]);
        chk({tag, ".rd_phy_busy_1"}, 32'(rd_phy_busy_1), fq[nspec + r0]);
      end
      if (track) chk({tag, ".conserve"}, 32'(free_count) + 32'(inflight.size()), 32);
    end
    @(posedge clk);
    rel = retire_valid && retire_has_rd && (rd_phy_old_commit != 6'd0);
    if (rst) begin
      model_reset();
    end else begin
      if (rdy && !flush) begin
        if (alloc_req[0]) inflight.push_back(fq[nspec]);
        if (alloc_req[1]) inflight.push_back(fq[nspec + r0]);
        nspec += n;
      end
      if (rel) begin
        fq.push_back(int'(rd_phy_old_commit));
        void'(fq.pop_front());
        nspec--;
        if (track && inflight.size() > 0) void'(inflight.pop_front());
      end
      if (flush) nspec = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; alloc_req = 2'b00;
    retire_valid = 1'b0; retire_has_rd = 1'b0; rd_phy_old_commit = 6'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
  endtask

  initial begin
    track = 1'b0;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    step("reset0");
    rst = 1'b0;

    // Reset image
    step("t1_reset_image");

    // Drain all 32 tags two at a time, then try to allocate from empty
    alloc_req = 2'b11;
    for (int i = 0; i < 16; i++) step("t2_drain");
    alloc_req = 2'b11; step("t2_empty_req11");
    alloc_req = 2'b01; step("t2_empty_req01");

    // One tag back from empty: pair refused, single granted
    alloc_req = 2'b00; retire_valid = 1'b1; retire_has_rd = 1'b1; rd_phy_old_commit = 6'd5;
    step("t3_retire5");
    idle_inputs();
    alloc_req = 2'b11; step("t3_req11_refused");
    alloc_req = 2'b01; step("t3_req01_grant5");
    alloc_req = 2'b10; step("t3_after");

    // Flush with same-cycle retire, then reach the released tag at the tail
    do_reset();
    alloc_req = 2'b11; step("t4_alloc_a");
    alloc_req = 2'b11; step("t4_alloc_b");
    alloc_req = 2'b11; flush = 1'b1;
    retire_valid = 1'b1; retire_has_rd = 1'b1; rd_phy_old_commit = 6'd7;
    step("t4_flush_retire");
    idle_inputs();
    step("t4_after_flush");
    alloc_req = 2'b11;
    for (int i = 0; i < 16; i++) step("t4_walk_to_7");
    alloc_req = 2'b00; step("t4_empty");

    // Retires that must not release anything
    do_reset();
    alloc_req = 2'b11; step("t5_alloc");
    alloc_req = 2'b00; retire_valid = 1'b1; retire_has_rd = 1'b0; rd_phy_old_commit = 6'd9;
    step("t5_no_rd");
    retire_has_rd = 1'b1; rd_phy_old_commit = 6'd0;
    step("t5_x0");
    idle_inputs(); step("t5_hold");
    flush = 1'b1; step("t5_flush");
    idle_inputs(); step("t5_after_flush");
    alloc_req = 2'b10; step("t5_slot1_only");
    alloc_req = 2'b00; step("t5_after_slot1");

    // Randomized traffic with in-order retire of allocated tags; reset mid-run
    do_reset();
    track = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      idle_inputs();
      alloc_req = 2'($urandom_range(0, 3));
      if (inflight.size() > 0 && $urandom_range(0, 99) < 55) begin
        retire_valid      = 1'b1;
        retire_has_rd     = 1'b1;
        rd_phy_old_commit = 6'(inflight[0]);
      end else if ($urandom_range(0, 9) == 0) begin
        retire_valid      = 1'b1;
        retire_has_rd     = 1'b0;
        rd_phy_old_commit = 6'($urandom_range(1, 63));
      end
      if (cyc == 150) begin
        rst = 1'b1;
        flush = 1'b1;
      end
      step(cyc == 151 ? "t6_post_reset" : "t6_random");
    end
    idle_inputs();
    step("t6_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
